// File: rtl/nibble_serial_add_seq_pkg.sv
// nibble_serial_add_seq_pkg: shared state encoding and sizing helpers for the nibble-serial adder
package nibble_serial_add_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NIBBLE_W = 4;

    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_add_seq_add4_slice.sv
// add4_slice: combinational 4-bit adder slice, functionally equivalent to the library 4-bit adder cell
module add4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};

endmodule

// File: rtl/nibble_serial_add_seq.sv
// nibble_serial_add_seq: WIDTH-bit add/subtract over WIDTH/4 cycles, reusing one 4-bit slice LSB-first
module nibble_serial_add_seq
    import nibble_serial_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CW      = cnt_w(NIBBLES);

    if (WIDTH % NIBBLE_W != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_add_seq: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [3:0]       s;
    logic             co;
    logic             last;

    add4_slice u_slice (
        .a  (a_q[NIBBLE_W-1:0]),
        .b  (b_q[NIBBLE_W-1:0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    assign last      = cnt == CW'(NIBBLES - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                                   (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Subtraction is A + ~B + 1: invert B at capture and seed the carry with in_sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            out_sum <= '0;
            out_co  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_q   <= in_a;
            b_q   <= in_sub ? ~in_b : in_b;
            carry <= in_sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_q   <= a_q >> NIBBLE_W;
            b_q   <= b_q >> NIBBLE_W;
            res_q <= {s, res_q[WIDTH-1:NIBBLE_W]};
            carry <= co;
            if (!last) cnt <= cnt + CW'(1);
            if (last) begin
                out_sum <= {s, res_q[WIDTH-1:NIBBLE_W]};
                out_co  <= co;
            end
        end
    end

endmodule
